// File: rtl/sp_ram_ctrl.sv
// Single-port data memory with valid/ready requests, byte enables and a post-reset clear sequence.
// Define MEM_OUTREG_EN to add a registered read output stage (two-cycle read latency).
module sp_ram_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;
    logic                  in_range;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // The write port is shared: the clear pointer owns it in INIT, the request port in RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_be    = req_be;
        rd_fire   = 1'b0;
        in_range  = ({1'b0, req_addr} < DEPTH_W);
        rd_data   = '0;
        if (in_range) begin
            rd_data = mem_q[req_addr];
        end
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
                mem_be    = '1;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we  = req_valid && req_write && in_range;
                rd_fire = req_valid && !req_write;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: the array has no reset; the INIT sequence clears it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we && mem_be[i]) begin
                mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

`ifdef MEM_OUTREG_EN
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    always_comb begin
        s1_valid_d  = rd_fire;
        s1_data_d   = rd_fire ? rd_data : s1_data_q;
        rsp_valid_d = s1_valid_q;
        rsp_rdata_d = s1_valid_q ? s1_data_q : rsp_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end
`else
    always_comb begin
        rsp_valid_d = rd_fire;
        rsp_rdata_d = rd_fire ? rd_data : rsp_rdata_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Self-checking bench: two instances (DEPTH 256 and 200) share one stimulus stream and are
// compared every cycle against a behavioural memory model plus a table of directed vectors.
module tb_sp_ram_ctrl;

`ifdef MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;

    logic [1:0]  ready_w, done_w, rv_w;
    logic [15:0] rd_w [2];

    always #5 clk = ~clk;

    sp_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256)) u_dut_256 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_w[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv_w[0]), .rsp_rdata(rd_w[0]), .init_done(done_w[0])
    );

    sp_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200)) u_dut_200 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_w[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv_w[1]), .rsp_rdata(rd_w[1]), .init_done(done_w[1])
    );

    typedef struct {
        int          k;
        int          due;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [15:0] d;
        logic [1:0]  b;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          edges [2];
    logic [15:0] mem_m [2][256];
    logic [15:0] last_rd [2];
    exp_t        expq[$];
    logic [15:0] obs0[$];
    logic [15:0] obs1[$];
    vec_t        tbl [15];

    function automatic int dep(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) mem_m[k][a] = '0;
            edges[k]   = 0;
            last_rd[k] = '0;
        end
        expq.delete();
    endtask

    // Applies the request rules at one rising edge: ready once DEPTH clear cycles have elapsed.
    task automatic model_edge();
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            if (edges[k] >= dep(k) && req_valid) begin
                if (req_write) begin
                    if (int'(req_addr) < dep(k)) begin
                        for (int b = 0; b < 2; b++)
                            if (req_be[b]) mem_m[k][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_t e;
                    e.k    = k;
                    e.due  = cyc + LAT - 1;
                    e.data = (int'(req_addr) < dep(k)) ? mem_m[k][req_addr] : 16'h0000;
                    expq.push_back(e);
                end
            end
            edges[k]++;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic exp_rdy;
            logic exp_v;
            int   idx;
            exp_rdy = rst_n && (edges[k] >= dep(k));
            exp_v   = 1'b0;
            idx     = -1;
            for (int i = 0; i < expq.size(); i++) begin
                if (expq[i].k == k) begin
                    idx = i;
                    break;
                end
            end
            if (idx >= 0 && expq[idx].due <= cyc) begin
                exp_v      = 1'b1;
                last_rd[k] = expq[idx].data;
                expq.delete(idx);
            end
            if (rv_w[k]) begin
                if (k == 0) obs0.push_back(rd_w[k]);
                else        obs1.push_back(rd_w[k]);
            end
            check($sformatf("req_ready[%0d]", k), 32'(ready_w[k]), 32'(exp_rdy));
            check($sformatf("init_done[%0d]", k), 32'(done_w[k]), 32'(exp_rdy));
            check($sformatf("rsp_valid[%0d]", k), 32'(rv_w[k]), 32'(exp_v));
            check($sformatf("rsp_rdata[%0d]", k), 32'(rd_w[k]), 32'(last_rd[k]));
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic [1:0] b);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = b;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    endtask

    initial begin
        int nr;
        tbl[0]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 8'h10, 16'hABCD, 2'b11, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b1, 8'h10, 16'h1234, 2'b01, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hAB34, 16'hAB34};
        tbl[4]  = '{1'b1, 8'h01, 16'h0001, 2'b11, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 8'h02, 16'h0002, 2'b11, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 8'h03, 16'h0003, 2'b11, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b0, 8'h01, 16'h0000, 2'b00, 16'h0001, 16'h0001};
        tbl[8]  = '{1'b0, 8'h02, 16'h0000, 2'b00, 16'h0002, 16'h0002};
        tbl[9]  = '{1'b0, 8'h03, 16'h0000, 2'b00, 16'h0003, 16'h0003};
        tbl[10] = '{1'b1, 8'd250, 16'hFFFF, 2'b11, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 8'd250, 16'h0000, 2'b00, 16'hFFFF, 16'h0000};
        tbl[12] = '{1'b0, 8'd199, 16'h0000, 2'b00, 16'h0000, 16'h0000};
        tbl[13] = '{1'b1, 8'h10, 16'hFFFF, 2'b00, 16'h0000, 16'h0000};
        tbl[14] = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hAB34, 16'hAB34};

        model_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // Requests during the clear sequence must be ignored.
        repeat (150) step(1'b1, 1'b1, 8'h00, 16'h9999, 2'b11);
        idle(120);

        for (int a = 0; a < 256; a++) step(1'b1, 1'b0, 8'(a), 16'h0000, 2'b00);
        idle(3);

        obs0.delete();
        obs1.delete();
        nr = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
            if (!tbl[i].w) nr++;
        end
        idle(3);
        check("tbl_rsp_count0", 32'(obs0.size()), 32'(nr));
        check("tbl_rsp_count1", 32'(obs1.size()), 32'(nr));
        begin
            int j;
            j = 0;
            for (int i = 0; i < 15; i++) begin
                if (!tbl[i].w) begin
                    check($sformatf("tbl%0d_d256", i), 32'(j < obs0.size() ? obs0[j] : 16'hDEAD), 32'(tbl[i].e0));
                    check($sformatf("tbl%0d_d200", i), 32'(j < obs1.size() ? obs1[j] : 16'hDEAD), 32'(tbl[i].e1));
                    j++;
                end
            end
        end

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                 16'($urandom), 2'($urandom));
        end
        idle(3);

        // Reset while a read is in flight: the response must never appear.
        step(1'b1, 1'b1, 8'h07, 16'h5555, 2'b11);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h07;
        @(posedge clk);
        cyc++;
        model_edge();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_rsp_valid[%0d]", k), 32'(rv_w[k]), 32'd0);
            check($sformatf("rst_rsp_rdata[%0d]", k), 32'(rd_w[k]), 32'd0);
            check($sformatf("rst_req_ready[%0d]", k), 32'(ready_w[k]), 32'd0);
        end
        @(negedge clk);
        check_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(260);
        obs0.delete();
        obs1.delete();
        step(1'b1, 1'b0, 8'h07, 16'h0000, 2'b00);
        idle(3);
        check("mid_rst_rd7_d256", 32'(obs0.size() > 0 ? obs0[0] : 16'hDEAD), 32'h0);
        check("mid_rst_rd7_d200", 32'(obs1.size() > 0 ? obs1[0] : 16'hDEAD), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_ctrl.md
# sp_ram_ctrl

Parametrised single-port synchronous data memory with a valid/ready request port, per-byte write enables, and a read-response valid strobe. After reset, a hardware clear sequence zeroes every word. It is the CPU's data-memory block. It generalises the earlier fixed 16-bit RAM in width, depth, byte masking, out-of-range handling and optional output pipelining.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  one-cycle strobe: rsp_rdata carries a read result.
- rsp_rdata  out  DATA_WIDTH  read data; holds its value until the next read response.
- init_done  out  1  high once the clear sequence has completed.

## Operation
- Reset state for all outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- FSM has two states, INIT and RUN. Reset forces INIT with clear pointer = 0.
- INIT:
  - Each cycle writes 0 to ram[ptr], then increments ptr.
  - After the cycle that writes ptr = DEPTH-1, the FSM moves to RUN.
  - req_ready=0; requests are ignored.
- RUN: req_ready=1 continuously. A request is accepted when req_valid && req_ready.
- Accepted write:
  - For each i with req_be[i]=1, the byte is written.
  - Bytes with req_be[i]=0 are unchanged.
  - No response is produced; rsp_rdata is unchanged.
- Accepted write with req_be all zero: no state change.
- Accepted read: returns ram[req_addr] with rsp_valid high for exactly one cycle.
- Out-of-range address (req_addr ≥ DEPTH):
  - Write is dropped.
  - Read still produces a response, with rsp_rdata=0.
- One operation per cycle. A read on the cycle after a write to the same address returns the new data.
- Reset asserted mid-operation:
  - Outputs return immediately to their reset values.
  - In-flight responses are discarded.
  - INIT re-runs after reset release; memory is re-cleared.

## Timing
- Clear sequence takes exactly DEPTH cycles after rst_n deasserts.
- req_ready and init_done rise together on the first RUN cycle and stay high until reset.
- Read latency without MEM_OUTREG_EN: read accepted at edge N → rsp_valid=1 and rsp_rdata valid during cycle N+1.
- Read latency with MEM_OUTREG_EN: rsp_valid and data appear in cycle N+2.
- Back-to-back reads are fully pipelined: one response per cycle, in request order.
- rsp has no backpressure; the consumer must sink every response.
- Address and data inputs are sampled only on the accepting edge.

## Configuration
- MEM_OUTREG_EN defined: adds a registered output stage after the RAM read.
  - Read latency is 2 cycles.
  - rsp_valid is delayed by the same 2 cycles.
  - Both pipeline stages reset to 0.
- MEM_OUTREG_EN undefined: read latency is 1 cycle.
- Request-side behaviour is identical in both builds.

## Test plan
- Reset then release with DEPTH=256:
  - req_ready and init_done stay 0 for 256 cycles, then rise to 1.
  - A read of every address returns 0.
- Partial write, then read:
  - Write 0xABCD to addr 0x10 with be=2'b11.
  - Then write 0x1234 to addr 0x10 with be=2'b01.
  - Read addr 0x10 → rsp_rdata=0xAB34 with rsp_valid 1 cycle later (2 with MEM_OUTREG_EN).
- Back-to-back reads:
  - Stimulus: write 0x0001, 0x0002, 0x0003 to addrs 1, 2, 3, then read 1, 2, 3 on consecutive cycles.
  - Expected: three consecutive rsp_valid cycles returning 0x0001, 0x0002, 0x0003.
- Out of range with DEPTH=200:
  - Write 0xFFFF to addr 250, then read addr 250 → rsp_rdata=0.
  - Read addr 199 → 0.
- Reset mid-run:
  - Write 0x5555 to addr 7, issue a read, and pull rst_n low before the response.
  - Expected: rsp_valid is never seen high.
  - After the re-clear, a read of addr 7 returns 0.
- Requests during INIT:
  - Drive req_valid=1 with a write of 0x9999 to addr 0 during the clear sequence.
  - After init_done, a read of addr 0 returns 0.
